bus_status_bank: RTL



---
 rtl/bus_status_bank_pkg.sv | 20 ++
 rtl/bus_status_chan.sv | 32 +++
 rtl/bus_status_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/bus_status_bank_pkg.sv
// bus_status_bank_pkg: register-bus field layout shared by the status bank and its channel slice.
package bus_status_bank_pkg;
  localparam int BUS_ADDR_W      = 16;
  localparam int BUS_DATA_W      = 32;
  localparam int BUS_CHAN_STRIDE = 4;
  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  rd_req;
    logic                  reset_l;
    logic                  clk;
  } bus_in_t;
  typedef struct packed {
    logic                  irq;
    logic                  wr_ack;
    logic                  rd_ack;
    logic [BUS_DATA_W-1:0] rd_data;
  } bus_out_t;
  localparam int BUS_IN_WIDTH  = $bits(bus_in_t);
  localparam int BUS_OUT_WIDTH = $bits(bus_out_t);
endpackage

// File: rtl/bus_status_chan.sv
// bus_status_chan: one status channel -- input register, sticky capture where set wins over
// clear-on-read, and a shadow register loaded by the bank-wide snapshot.
module bus_status_chan #(
  parameter int                   DATAWIDTH   = 32,
  parameter logic [DATAWIDTH-1:0] STICKY_MASK = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATAWIDTH-1:0] i_in,
  input  logic                 i_clr,
  input  logic                 i_cap,
  output logic [DATAWIDTH-1:0] o_val,
  output logic [DATAWIDTH-1:0] o_shadow,
  output logic                 o_stk_any
);
  logic [DATAWIDTH-1:0] r_cur, r_stk, r_shadow;
  assign o_val     = (r_cur & ~STICKY_MASK) | (r_stk & STICKY_MASK);
  assign o_shadow  = r_shadow;
  assign o_stk_any = |r_stk;
  // OR-ing r_cur after the clear keeps a bit that is asserted during the clearing read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur    <= '0;
      r_stk    <= '0;
      r_shadow <= '0;
    end else begin
      r_cur    <= i_in;
      r_stk    <= ((r_stk & {DATAWIDTH{~i_clr}}) | r_cur) & STICKY_MASK;
      r_shadow <= i_cap ? o_val : r_shadow;
    end
  end
endmodule

// File: rtl/bus_status_bank.sv
// bus_status_bank: NCHAN read-only status words on the register bus, sticky clear-on-read bits and
// a channel-0 triggered snapshot. Define BUS_STATUS_BANK_IRQ_EN to drive irq from all sticky bits.
module bus_status_bank
  import bus_status_bank_pkg::*;
#(
  parameter int                    NCHAN       = 4,
  parameter int                    DATAWIDTH   = 32,
  parameter int                    OFFSET      = 0,
  parameter logic [BUS_ADDR_W-1:0] BUS_ADDR    = '0,
  parameter logic [DATAWIDTH-1:0]  STICKY_MASK = '0,
  parameter bit                    SNAPSHOT    = 1'b1
) (
  input  logic [BUS_IN_WIDTH-1:0]    bus_in,
  output logic [BUS_OUT_WIDTH-1:0]   bus_out,
  input  logic [NCHAN*DATAWIDTH-1:0] in,
  output logic [NCHAN-1:0]           rd_pulse
);
  localparam logic [BUS_ADDR_W-1:0] L_SPAN = BUS_ADDR_W'(NCHAN * BUS_CHAN_STRIDE);
  bus_in_t               w_bus;
  bus_out_t              w_out;
  logic                  w_bus_clk, w_bus_reset_l, w_hit, w_irq, w_unused;
  logic [BUS_ADDR_W-1:0] w_byte, w_off;
  logic [3:0]            w_k;
  logic [NCHAN-1:0]      w_sel, w_clr, w_cap, w_stk_any;
  logic [DATAWIDTH-1:0]  w_val [NCHAN];
  logic [DATAWIDTH-1:0]  w_shadow [NCHAN];
  logic [DATAWIDTH-1:0]  w_rd_val;
  logic                  r_rd_ack;
  logic [BUS_DATA_W-1:0] r_rd_data;
  logic [NCHAN-1:0]      r_rd_pulse;
  assign w_bus         = bus_in;
  assign w_bus_clk     = w_bus.clk;
  assign w_bus_reset_l = w_bus.reset_l;
  assign w_byte        = {w_bus.addr[BUS_ADDR_W-1:2], 2'b00};
  assign w_off         = w_byte - BUS_ADDR;
  assign w_hit         = w_bus.rd_req && (w_byte >= BUS_ADDR) && (w_off < L_SPAN);
  assign w_k           = w_off[5:2];
  assign w_unused      = ^{w_bus.addr[1:0], w_stk_any};
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    // with snapshots, channels 1..N-1 are cleared and captured by the channel 0 read only
    assign w_sel[i] = w_hit && (w_k == 4'(i));
    assign w_clr[i] = (SNAPSHOT && i != 0) ? w_sel[0] : w_sel[i];
    assign w_cap[i] = SNAPSHOT && (i != 0) && w_sel[0];
    bus_status_chan #(
      .DATAWIDTH  (DATAWIDTH),
      .STICKY_MASK(STICKY_MASK)
    ) u_chan (
      .i_clk    (w_bus_clk),
      .i_rst_n  (w_bus_reset_l),
      .i_in     (in[i*DATAWIDTH +: DATAWIDTH]),
      .i_clr    (w_clr[i]),
      .i_cap    (w_cap[i]),
      .o_val    (w_val[i]),
      .o_shadow (w_shadow[i]),
      .o_stk_any(w_stk_any[i])
    );
  end
  always_comb begin
    w_rd_val = '0;
    for (int j = 0; j < NCHAN; j++)
      w_rd_val = w_sel[j] ? ((SNAPSHOT && j != 0) ? w_shadow[j] : w_val[j]) : w_rd_val;
  end
  always_ff @(posedge w_bus_clk or negedge w_bus_reset_l) begin
    if (!w_bus_reset_l) begin
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_rd_ack   <= w_hit;
      r_rd_data  <= BUS_DATA_W'(w_rd_val) << OFFSET;
      r_rd_pulse <= w_sel;
    end
  end
`ifdef BUS_STATUS_BANK_IRQ_EN
  logic r_irq;
  always_ff @(posedge w_bus_clk or negedge w_bus_reset_l) begin
    if (!w_bus_reset_l) r_irq <= 1'b0;
    else r_irq <= |w_stk_any;
  end
  assign w_irq = r_irq;
`else
  assign w_irq = 1'b0;
`endif
  assign w_out.irq     = w_irq;
  assign w_out.wr_ack  = 1'b0;
  assign w_out.rd_ack  = r_rd_ack;
  assign w_out.rd_data = r_rd_data;
  assign bus_out       = w_out;
  assign rd_pulse      = r_rd_pulse;
endmodule
